// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the line memory, latches each fetched line
// into an instruction register and offers it to execute over valid/ready.
module fetch_sequencer #(
    parameter int                    IP_WIDTH   = 8,
    parameter int                    LINE_WIDTH = 32,
    parameter logic [LINE_WIDTH-1:0] HALT_WORD  = 32'hffffffff
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LINE_WIDTH-1:0] mem_line,
    output logic                  mem_en,
    output logic [IP_WIDTH-1:0]   mem_ip,
    output logic [LINE_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump_en,
    input  logic [IP_WIDTH-1:0]   jump_target,
    output logic                  halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                state, state_d;
    logic [IP_WIDTH-1:0]   ip, ip_d;
    logic [LINE_WIDTH-1:0] instr_q, instr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ip      <= '0;
            instr_q <= '0;
        end else begin
            state   <= state_d;
            ip      <= ip_d;
            instr_q <= instr_d;
        end
    end

    // ip only moves on the accepting handshake, so it is stable across FETCH
    always_comb begin
        state_d = state;
        ip_d    = ip;
        instr_d = instr_q;
        case (state)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (mem_line == HALT_WORD) begin
                    state_d = HALT;
                end else begin
                    instr_d = mem_line;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    state_d = FETCH;
                    ip_d    = jump_en ? jump_target : ip + 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_en      = (state == FETCH);
    assign mem_ip      = ip;
    assign instr       = instr_q;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// program walk checked against a program-level model of ip and issued lines.
module tb_fetch_sequencer;

    localparam logic [31:0] HALTW = 32'hffffffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mem_line;
    logic        mem_en;
    logic [7:0]  mem_ip;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_target = 8'h00;
    logic        halted;

    logic [31:0] mem_arr [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // combinational line memory
    assign mem_line = mem_arr[mem_ip];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mem_line(mem_line),
        .mem_en(mem_en), .mem_ip(mem_ip), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump_en(jump_en), .jump_target(jump_target), .halted(halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem(input logic [31:0] fill);
        for (int i = 0; i < 256; i++) mem_arr[i] = fill;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_target = 8'h00;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem(32'h0000_0001);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            checks++; if (mem_ip !== 8'h00) begin errors++; $display("FAIL reset_ip: got %h want 00", mem_ip); end
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
            checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
            tick();
        end
    endtask

    task automatic test_program();
        clear_mem(HALTW);
        mem_arr[0] = 32'h03002336; mem_arr[1] = 32'h02000011; mem_arr[2] = HALTW;
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (mem_en !== 1'b1 || mem_ip !== 8'h00) begin errors++; $display("FAIL prog_fetch0: got en=%b ip=%h want en=1 ip=00", mem_en, mem_ip); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h03002336) begin errors++; $display("FAIL prog_issue0: got v=%b instr=%h want v=1 instr=03002336", instr_valid, instr); end
        tick();
        checks++; if (mem_en !== 1'b1 || mem_ip !== 8'h01) begin errors++; $display("FAIL prog_fetch1: got en=%b ip=%h want en=1 ip=01", mem_en, mem_ip); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h02000011) begin errors++; $display("FAIL prog_issue1: got v=%b instr=%h want v=1 instr=02000011", instr_valid, instr); end
        tick();
        checks++; if (mem_ip !== 8'h02) begin errors++; $display("FAIL prog_fetch2: got ip=%h want 02", mem_ip); end
        tick();
        checks++; if (halted !== 1'b1 || mem_ip !== 8'h02 || instr_valid !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL prog_halt: got h=%b ip=%h v=%b en=%b want h=1 ip=02 v=0 en=0", halted, mem_ip, instr_valid, mem_en); end
        checks++; if (instr !== 32'h02000011) begin errors++; $display("FAIL prog_halt_instr: got %h want 02000011", instr); end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        clear_mem(HALTW);
        mem_arr[0] = 32'h03002336; mem_arr[1] = 32'h02000011;
        do_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h03002336 || mem_ip !== 8'h00 || mem_en !== 1'b0) begin
                errors++; $display("FAIL stall_hold: got v=%b instr=%h ip=%h en=%b want v=1 instr=03002336 ip=00 en=0", instr_valid, instr, mem_ip, mem_en); end
            tick();
        end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        checks++; if (mem_ip !== 8'h01 || mem_en !== 1'b1) begin errors++; $display("FAIL stall_release: got ip=%h en=%b want ip=01 en=1", mem_ip, mem_en); end
    endtask

    task automatic test_jump();
        clear_mem(HALTW);
        mem_arr[0] = 32'h11111111; mem_arr[1] = 32'h22222222;
        do_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        instr_ready = 1'b1; tick(); instr_ready = 1'b0; tick();
        jump_en = 1'b1; jump_target = 8'h05;
        tick(); tick();
        checks++; if (mem_ip !== 8'h01 || instr_valid !== 1'b1 || instr !== 32'h22222222) begin
            errors++; $display("FAIL jump_ignored: got ip=%h v=%b instr=%h want ip=01 v=1 instr=22222222", mem_ip, instr_valid, instr); end
        jump_target = 8'h00; instr_ready = 1'b1; tick(); instr_ready = 1'b0; jump_en = 1'b0;
        checks++; if (mem_ip !== 8'h00 || mem_en !== 1'b1) begin errors++; $display("FAIL jump_taken: got ip=%h en=%b want ip=00 en=1", mem_ip, mem_en); end
    endtask

    task automatic test_wrap();
        clear_mem(HALTW);
        mem_arr[0] = 32'h0000abcd; mem_arr[255] = 32'h12345678;
        do_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        instr_ready = 1'b1; jump_en = 1'b1; jump_target = 8'hff; tick(); jump_en = 1'b0;
        checks++; if (mem_ip !== 8'hff || mem_en !== 1'b1) begin errors++; $display("FAIL wrap_at_ff: got ip=%h en=%b want ip=ff en=1", mem_ip, mem_en); end
        tick();
        checks++; if (instr !== 32'h12345678 || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_instr: got %h v=%b want 12345678 v=1", instr, instr_valid); end
        tick(); instr_ready = 1'b0;
        checks++; if (mem_ip !== 8'h00 || mem_en !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL wrap_to_00: got ip=%h en=%b h=%b want ip=00 en=1 h=0", mem_ip, mem_en, halted); end
    endtask

    task automatic test_reset_mid();
        clear_mem(HALTW);
        mem_arr[0] = 32'h0badf00d; mem_arr[1] = 32'h00000042;
        do_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        instr_ready = 1'b1; tick(); instr_ready = 1'b0; tick();
        checks++; if (instr_valid !== 1'b1 || mem_ip !== 8'h01) begin errors++; $display("FAIL mid_setup: got v=%b ip=%h want v=1 ip=01", instr_valid, mem_ip); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || mem_ip !== 8'h00 || mem_en !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got v=%b instr=%h ip=%h en=%b h=%b want all zero", instr_valid, instr, mem_ip, mem_en, halted); end
        tick();
        checks++; if (mem_en !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_idle: got en=%b v=%b want 0 0", mem_en, instr_valid); end
        mem_arr[0] = HALTW;
        start = 1'b1; tick(); tick();
        for (int c = 0; c < 3; c++) begin
            checks++; if (halted !== 1'b1 || mem_en !== 1'b0 || mem_ip !== 8'h00 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL halt_sticky: got h=%b en=%b ip=%h v=%b want h=1 en=0 ip=00 v=0", halted, mem_en, mem_ip, instr_valid); end
            tick();
        end
        start = 1'b0;
    endtask

    // Program-level model: ip walks sequentially or jumps on each accepted line,
    // every issued instr must equal the memory line at the model ip.
    task automatic test_random();
        logic [7:0] exp_ip;
        logic       done;
        for (int run = 0; run < 4; run++) begin
            for (int i = 0; i < 256; i++)
                mem_arr[i] = ($urandom_range(0, 15) == 0) ? HALTW : ($urandom & 32'hfffffffe);
            mem_arr[0] = 32'h00000100;
            do_reset();
            exp_ip = 8'h00;
            done = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            for (int n = 0; n < 120 && !done; n++) begin
                checks++; if (mem_en !== 1'b1 || mem_ip !== exp_ip) begin
                    errors++; $display("FAIL rnd_fetch: got en=%b ip=%h want en=1 ip=%h", mem_en, mem_ip, exp_ip); end
                tick();
                if (mem_arr[exp_ip] == HALTW) begin
                    checks++; if (halted !== 1'b1 || mem_ip !== exp_ip || instr_valid !== 1'b0) begin
                        errors++; $display("FAIL rnd_halt: got h=%b ip=%h v=%b want h=1 ip=%h v=0", halted, mem_ip, instr_valid, exp_ip); end
                    done = 1'b1;
                end else begin
                    checks++; if (instr_valid !== 1'b1 || instr !== mem_arr[exp_ip]) begin
                        errors++; $display("FAIL rnd_issue: got v=%b instr=%h want v=1 instr=%h", instr_valid, instr, mem_arr[exp_ip]); end
                    instr_ready = 1'b0;
                    for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
                        jump_en = 1'($urandom); jump_target = 8'($urandom);
                        tick();
                        checks++; if (instr_valid !== 1'b1 || mem_en !== 1'b0 || mem_ip !== exp_ip) begin
                            errors++; $display("FAIL rnd_stall: got v=%b en=%b ip=%h want v=1 en=0 ip=%h", instr_valid, mem_en, mem_ip, exp_ip); end
                    end
                    instr_ready = 1'b1;
                    jump_en = ($urandom_range(0, 3) == 0);
                    jump_target = 8'($urandom);
                    exp_ip = jump_en ? jump_target : 8'(exp_ip + 8'd1);
                    tick();
                    instr_ready = 1'b0; jump_en = 1'b0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_jump();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
